// File: rtl/pattern_det_pkg.sv
// Shared types for the serial pattern detector.
//   ST_IDLE/ST_FILL/ST_HUNT : encodings exposed on the st debug port
//   state_t                 : FSM state enum built on those encodings
package pattern_det_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_HUNT = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    HUNT = ST_HUNT
  } state_t;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter.
//   clk, rst : clock, async active-high reset
//   inc      : count up by one unless already at maximum
//   clr      : synchronous clear (wins over inc)
//   value    : current count
//   sat      : value is at its maximum
module sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         sat
);

  assign sat = (value == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !sat) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pattern_det.sv
// Configurable serial bit-pattern detector.
//   clk, rst    : clock, async active-high reset
//   cfg_load    : load cfg_pat/cfg_len/cfg_overlap (legal length 2..PAT_W)
//   cfg_pat     : pattern, bit cfg_len-1 received first
//   cfg_len     : active pattern length
//   cfg_overlap : 1 = overlapping matches, 0 = non-overlapping
//   in_vld      : qualifies in_bit
//   in_bit      : serial data
//   y           : registered one-cycle match pulse
//   near        : registered, next beat can complete a match
//   match_cnt   : saturating match count
//   cnt_sat     : match_cnt at maximum
//   cfg_err     : one-cycle pulse on rejected configuration
//   st          : FSM state (IDLE=0, FILL=1, HUNT=2)
module pattern_det
  import pattern_det_pkg::*;
#(
  parameter int unsigned PAT_W = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             in_vld,
  input  logic             in_bit,
  output logic             y,
  output logic             near,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat,
  output logic             cfg_err,
  output logic [1:0]       st
);

  state_t           state, state_n;
  logic [PAT_W-1:0] pat, win, win_n, mask, mask_lo;
  logic [LEN_W-1:0] len, cnt, cnt_n;
  logic             ovl;
  logic             load_ok, load_bad, beat, hit, near_n;

  always_comb begin
    load_ok  = cfg_load && (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(PAT_W));
    load_bad = cfg_load && !load_ok;
    beat     = in_vld && !cfg_load && (state == FILL || state == HUNT);

    // mask selects window[len-1:0]; mask_lo selects window[len-2:0]
    mask    = '0;
    mask_lo = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask[i]    = (i < 32'(len));
      mask_lo[i] = ((i + 1) < 32'(len));
    end

    win_n   = win;
    cnt_n   = cnt;
    state_n = state;

    if (beat) begin
      win_n = {win[PAT_W-2:0], in_bit};
      cnt_n = (cnt == len) ? cnt : cnt + LEN_W'(1);
    end

    hit    = beat && (cnt_n == len) && (((win_n ^ pat) & mask) == '0);
    near_n = (cnt_n >= len - LEN_W'(1)) && (((win_n ^ (pat >> 1)) & mask_lo) == '0);

    unique case (state)
      IDLE:    state_n = IDLE;
      FILL:    if (beat && cnt_n == len) state_n = HUNT;
      HUNT:    state_n = HUNT;
      default: state_n = IDLE;
    endcase

    // Non-overlap restarts the fill so no matched bit is reused.
    if (hit && !ovl) begin
      cnt_n   = '0;
      state_n = FILL;
      near_n  = 1'b0;
    end

    if (state_n == IDLE) near_n = 1'b0;

    if (load_ok) begin
      state_n = FILL;
      cnt_n   = '0;
      win_n   = '0;
      near_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pat     <= '0;
      len     <= '0;
      ovl     <= 1'b0;
      win     <= '0;
      cnt     <= '0;
      y       <= 1'b0;
      near    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_n;
      win     <= win_n;
      cnt     <= cnt_n;
      y       <= hit;
      near    <= near_n;
      cfg_err <= load_bad;
      if (load_ok) begin
        pat <= cfg_pat;
        len <= cfg_len;
        ovl <= cfg_overlap;
      end
    end
  end

  sat_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit),
    .clr   (load_ok),
    .value (match_cnt),
    .sat   (cnt_sat)
  );

  assign st = state;

endmodule

// File: tb/tb_pattern_det.sv
module tb_pattern_det;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // instance A: default parameters
  logic       a_load = 1'b0, a_ovl = 1'b0, a_vld = 1'b0, a_bit = 1'b0;
  logic [7:0] a_pat = '0;
  logic [3:0] a_len = '0;
  logic       a_y, a_near, a_sat, a_err;
  logic [7:0] a_cnt;
  logic [1:0] a_st;

  // instance B: 2-bit match counter
  logic       b_load = 1'b0, b_ovl = 1'b0, b_vld = 1'b0, b_bit = 1'b0;
  logic [7:0] b_pat = '0;
  logic [3:0] b_len = '0;
  logic       b_y, b_near, b_sat, b_err;
  logic [1:0] b_cnt;
  logic [1:0] b_st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_det u_a (
    .clk(clk), .rst(rst), .cfg_load(a_load), .cfg_pat(a_pat), .cfg_len(a_len),
    .cfg_overlap(a_ovl), .in_vld(a_vld), .in_bit(a_bit), .y(a_y), .near(a_near),
    .match_cnt(a_cnt), .cnt_sat(a_sat), .cfg_err(a_err), .st(a_st)
  );

  pattern_det #(.CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .cfg_load(b_load), .cfg_pat(b_pat), .cfg_len(b_len),
    .cfg_overlap(b_ovl), .in_vld(b_vld), .in_bit(b_bit), .y(b_y), .near(b_near),
    .match_cnt(b_cnt), .cnt_sat(b_sat), .cfg_err(b_err), .st(b_st)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_beat(input logic b);
    a_vld = 1'b1;
    a_bit = b;
    tick();
    a_vld = 1'b0;
  endtask

  task automatic a_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    a_load = 1'b1;
    a_pat  = p;
    a_len  = l;
    a_ovl  = o;
    tick();
    a_load = 1'b0;
  endtask

  initial begin
    logic [6:0] bits;
    logic [6:0] y_exp, near_exp, st_hi;
    logic [3:0] s4;
    logic [2:0] s3;
    logic [5:0] by_exp, bsat_exp;
    logic [1:0] bcnt_exp [6];

    // reset state, before any clock edge
    #3;
    chk("rst_st", a_st, 0);
    chk("rst_y", a_y, 0);
    chk("rst_near", a_near, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_sat", a_sat, 0);
    chk("rst_err", a_err, 0);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores data
    for (int i = 0; i < 3; i++) begin
      a_beat(1'b1);
      chk($sformatf("idle_st[%0d]", i), a_st, 0);
      chk($sformatf("idle_y[%0d]", i), a_y, 0);
    end

    // overlapping 1011
    a_cfg(8'b0000_1011, 4'd4, 1'b1);
    chk("ov_load_st", a_st, 1);
    chk("ov_load_cnt", a_cnt, 0);
    bits     = 7'b1011011;
    y_exp    = 7'b0001001;
    near_exp = 7'b0010010;
    st_hi    = 7'b0001111;   // HUNT after beats 4..7
    for (int i = 0; i < 7; i++) begin
      a_beat(bits[6-i]);
      chk($sformatf("ov_y[%0d]", i + 1), a_y, y_exp[6-i]);
      chk($sformatf("ov_near[%0d]", i + 1), a_near, near_exp[6-i]);
      chk($sformatf("ov_st[%0d]", i + 1), a_st, st_hi[6-i] ? 2 : 1);
    end
    tick();
    chk("ov_y_idle", a_y, 0);
    chk("ov_cnt", a_cnt, 2);

    // non-overlapping 1011
    a_cfg(8'b0000_1011, 4'd4, 1'b0);
    chk("no_load_cnt", a_cnt, 0);
    y_exp    = 7'b0001000;
    near_exp = 7'b0010000;
    for (int i = 0; i < 7; i++) begin
      a_beat(bits[6-i]);
      chk($sformatf("no_y[%0d]", i + 1), a_y, y_exp[6-i]);
      chk($sformatf("no_near[%0d]", i + 1), a_near, near_exp[6-i]);
      chk($sformatf("no_st[%0d]", i + 1), a_st, 1);
    end
    chk("no_cnt", a_cnt, 1);

    // load mid-stream with a concurrent beat: beat dropped
    a_vld = 1'b1;
    a_bit = 1'b0;
    a_cfg(8'b0000_0110, 4'd4, 1'b1);
    a_vld = 1'b0;
    chk("mid_st", a_st, 1);
    chk("mid_cnt", a_cnt, 0);
    chk("mid_y", a_y, 0);
    s4 = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      a_beat(s4[3-i]);
      chk($sformatf("mid_y[%0d]", i + 1), a_y, (i == 3) ? 1 : 0);
      chk($sformatf("mid_st[%0d]", i + 1), a_st, (i == 3) ? 2 : 1);
    end
    chk("mid_cnt_end", a_cnt, 1);

    // illegal lengths rejected
    a_cfg(8'hFF, 4'd1, 1'b0);
    chk("err1_pulse", a_err, 1);
    chk("err1_st", a_st, 2);
    chk("err1_cnt", a_cnt, 1);
    tick();
    chk("err1_clear", a_err, 0);
    a_cfg(8'hFF, 4'd9, 1'b0);
    chk("err9_pulse", a_err, 1);
    chk("err9_st", a_st, 2);
    tick();
    chk("err9_clear", a_err, 0);
    s3 = 3'b110;
    for (int i = 0; i < 3; i++) begin
      a_beat(s3[2-i]);
      chk($sformatf("keep_y[%0d]", i + 1), a_y, (i == 2) ? 1 : 0);
    end
    chk("keep_cnt", a_cnt, 2);

    // async reset between edges during HUNT, y currently high
    rst = 1'b1;
    #1;
    chk("arst_st", a_st, 0);
    chk("arst_y", a_y, 0);
    chk("arst_near", a_near, 0);
    chk("arst_cnt", a_cnt, 0);
    chk("arst_sat", a_sat, 0);
    chk("arst_err", a_err, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_beat(s4[3-i]);
      chk($sformatf("post_st[%0d]", i + 1), a_st, 0);
      chk($sformatf("post_y[%0d]", i + 1), a_y, 0);
    end

    // saturating 2-bit counter, pattern 11 overlapping
    b_load = 1'b1;
    b_pat  = 8'b0000_0011;
    b_len  = 4'd2;
    b_ovl  = 1'b1;
    tick();
    b_load = 1'b0;
    chk("b_load_st", b_st, 1);
    by_exp   = 6'b011111;
    bsat_exp = 6'b000111;
    bcnt_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      b_vld = 1'b1;
      b_bit = 1'b1;
      tick();
      b_vld = 1'b0;
      chk($sformatf("b_y[%0d]", i + 1), b_y, by_exp[5-i]);
      chk($sformatf("b_cnt[%0d]", i + 1), b_cnt, bcnt_exp[i]);
      chk($sformatf("b_sat[%0d]", i + 1), b_sat, bsat_exp[5-i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_det.md
PATTERN_DET -- requirements
Module: pattern_det

Interface
REQ-001 Parameter PAT_W, default 8, SHALL set the maximum pattern length in bits (legal range 2..32).
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the saturating match counter.
REQ-003 Parameter LEN_W, default $clog2(PAT_W+1), SHALL set the width of cfg_len.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-high.
REQ-006 cfg_load  input  1  loads cfg_pat, cfg_len and cfg_overlap.
REQ-007 cfg_pat  input  PAT_W  pattern; bit cfg_len-1 is the first bit received, bit 0 the last.
REQ-008 cfg_len  input  LEN_W  active pattern length.
REQ-009 cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
REQ-010 in_vld  input  1  qualifies in_bit.
REQ-011 in_bit  input  1  serial data bit.
REQ-012 y  output  1  one-cycle match pulse.
REQ-013 near  output  1  the next beat can complete a match.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.
REQ-015 cnt_sat  output  1  match_cnt has saturated.
REQ-016 cfg_err  output  1  one-cycle pulse: rejected configuration.
REQ-017 st  output  2  current FSM state, for debug.

Function
REQ-018 The FSM SHALL have three states: IDLE (no valid configuration), FILL (beat count < len) and HUNT (beat count = len).
REQ-019 A cfg_load with 2 <= cfg_len <= PAT_W SHALL latch the configuration, clear the window, the beat count and match_cnt, and go to FILL from any state.
REQ-020 A cfg_load with an illegal cfg_len SHALL leave configuration and state unchanged and pulse cfg_err for one cycle.
REQ-021 cfg_load SHALL take priority over in_vld in the same cycle; that input beat is discarded.
REQ-022 In IDLE, in_vld SHALL be ignored.
REQ-023 In FILL or HUNT, each in_vld beat SHALL shift in_bit into window bit 0 and increment the beat count, saturating at len.
REQ-024 FILL SHALL move to HUNT on the beat that brings the count to len.
REQ-025 A match occurs on a beat when the updated count equals len and window[len-1:0] equals cfg_pat[len-1:0].
REQ-026 y SHALL be registered and high exactly in the cycle after the matching beat; latency is 1 clk.
REQ-027 On a match with cfg_overlap=1, the FSM SHALL stay in HUNT with the window intact.
REQ-028 On a match with cfg_overlap=0, the beat count SHALL clear and the FSM SHALL go to FILL, so no bit of the matched pattern is reused.
REQ-029 near SHALL be registered and high when count >= len-1 and window[len-2:0] equals cfg_pat[len-1:1].
REQ-030 near SHALL be forced low in the cycle after a non-overlap match.
REQ-031 match_cnt SHALL increment by 1 per match and saturate at 2^CNT_W-1.
REQ-032 cnt_sat SHALL be high whenever match_cnt equals its maximum value.
REQ-033 Window bits above len-1 SHALL NOT affect the match or near results.
REQ-034 The st encoding SHALL be IDLE=0, FILL=1, HUNT=2; value 3 SHALL recover to IDLE on the next clk.

Reset
REQ-035 Asserting rst SHALL immediately force state IDLE, y=0, near=0, match_cnt=0, cnt_sat=0, cfg_err=0, and clear the window and configuration, including mid-stream.
REQ-036 After rst deasserts, the block SHALL stay in IDLE until a legal cfg_load.

Structure
REQ-037 Package pattern_det_pkg SHALL hold the state enum (IDLE/FILL/HUNT) and the st encoding constants.
REQ-038 The saturating counter SHALL be one sub-module, sat_cnt, parameterised by width, with inc, clr, value and sat ports.

Verification (PAT_W=8, CNT_W=8 unless stated)
REQ-039 Load 1011, len 4, overlap=1; stream 1,0,1,1,0,1,1 -> y after beats 4 and 7, match_cnt=2, near high after beats 3 and 6.
REQ-040 Same stream with overlap=0 -> y after beat 4 only, match_cnt=1, st=FILL after beat 4.
REQ-041 CNT_W=2, pattern 11 len 2, overlap=1, six 1-bits -> match_cnt reaches 3, cnt_sat=1, y pulses 5 times.
REQ-042 cfg_load of 0110 len 4 in the same cycle as in_vld=1 mid-stream -> the beat is dropped, st=FILL, window and match_cnt are 0.
REQ-043 cfg_load with cfg_len=1, and separately cfg_len=9 -> a one-cycle cfg_err pulse each time; prior configuration still matches.
REQ-044 rst asserted between clock edges during HUNT -> all outputs 0 and st=IDLE before the next edge; subsequent in_vld is ignored until cfg_load.
